// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the serial pattern transmitter.
//   - pg_state_t : FSM state encoding (PG_IDLE, PG_SHIFT, PG_PAR, PG_FIN)
//   - PG_PAT_W   : default maximum pattern length in bits
//   - PG_CNT_W   : default width of the repeat-count field
//   - clamp_len  : maps a requested length of 0 or > pat_w onto pat_w
package pattern_pkg;

   localparam int PG_PAT_W = 8;
   localparam int PG_CNT_W = 4;

   typedef enum logic [1:0] {
      PG_IDLE  = 2'd0,
      PG_SHIFT = 2'd1,
      PG_PAR   = 2'd2,
      PG_FIN   = 2'd3
   } pg_state_t;

   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned pat_w);
      if (len == 0 || len > pat_w)
         return pat_w;
      else
         return len;
   endfunction

endpackage

// File: rtl/pattern_shift.sv
// pattern_shift: captured pattern word plus a down-counting bit index.
// Optional build macro: PATTERN_GEN_PARITY_EN (keeps a running even parity).
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          capture data/len, point index at bit len-1, clear parity
//   step          consume current bit: fold into parity, move index down
//   restart       start the next frame from the captured word (index = len-1)
//   data, len     pattern word and already-clamped length (used on load)
//   bit_o         captured bit at the current index
//   last          index is at bit 0
//   par_o         XOR of the bits stepped over since load/restart
module pattern_shift #(
   parameter int PAT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             restart,
   input  logic [PAT_W-1:0] data,
   input  logic [LEN_W-1:0] len,
   output logic             bit_o,
   output logic             last,
   output logic             par_o
);

   logic [PAT_W-1:0] data_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] idx_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_reg <= '0;
         len_reg  <= '0;
         idx_reg  <= '0;
      end else if (load) begin
         data_reg <= data;
         len_reg  <= len;
         idx_reg  <= len - LEN_W'(1);
      end else if (restart) begin
         idx_reg  <= len_reg - LEN_W'(1);
      end else if (step && idx_reg != '0) begin
         // At bit 0 the index holds; the owner restarts it before it could underflow.
         idx_reg  <= idx_reg - LEN_W'(1);
      end
   end

   // Mask-and-reduce avoids a variable part-select with a wider-than-needed index.
   assign bit_o = |(data_reg & (PAT_W'(1) << idx_reg));
   assign last  = (idx_reg == '0);

`ifdef PATTERN_GEN_PARITY_EN
   logic par_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         par_reg <= 1'b0;
      else if (load || restart)
         par_reg <= 1'b0;
      else if (step)
         par_reg <= par_reg ^ bit_o;
   end

   assign par_o = par_reg;
`else
   assign par_o = 1'b0;
`endif

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: serial pattern transmitter. Accepts a pattern word on a
// start/ready handshake and sends it MSB-first, one bit per clock, rpt+1 times
// back to back.
// Optional build macro: PATTERN_GEN_PARITY_EN appends an even-parity bit
// after every frame (PG_PAR state).
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   start       send request, accepted only while ready
//   pat_data    pattern word; the low pat_len bits are sent
//   pat_len     bits per frame; 0 or > PAT_W means PAT_W
//   rpt         extra repetitions (frames = rpt + 1)
//   ready       idle, able to accept
//   out         serial bit (0 whenever out_valid is low)
//   out_valid   out carries a pattern or parity bit
//   busy        from accept through the done cycle
//   done        one-cycle pulse after the last bit
// All outputs are decoded from registered state only.
module pattern_gen
   import pattern_pkg::*;
#(
   parameter int PAT_W = PG_PAT_W,
   parameter int CNT_W = PG_CNT_W,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pat_data,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [CNT_W-1:0] rpt,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   pg_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [LEN_W-1:0] len_clamped;
   logic             frame_more;
   logic             sh_load;
   logic             sh_step;
   logic             sh_restart;
   logic             sh_bit;
   logic             sh_last;
   logic             sh_par;

   assign len_clamped = LEN_W'(clamp_len(32'(pat_len), 32'(PAT_W)));
   assign frame_more  = (cnt_reg != '0);

   pattern_shift #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load    (sh_load),
      .step    (sh_step),
      .restart (sh_restart),
      .data    (pat_data),
      .len     (len_clamped),
      .bit_o   (sh_bit),
      .last    (sh_last),
      .par_o   (sh_par)
   );

   // Shift-register control. Without parity the next frame restarts straight
   // out of the last pattern bit so frames stay gapless; with parity the
   // restart happens in the PAR cycle instead.
   always_comb begin
      sh_load    = 1'b0;
      sh_step    = 1'b0;
      sh_restart = 1'b0;
      case (state_reg)
         PG_IDLE:  sh_load = start;
         PG_SHIFT: begin
`ifdef PATTERN_GEN_PARITY_EN
            sh_step = 1'b1;
`else
            if (sh_last && frame_more)
               sh_restart = 1'b1;
            else
               sh_step = 1'b1;
`endif
         end
         PG_PAR:   sh_restart = frame_more;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= PG_IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            PG_IDLE: begin
               if (start) begin
                  cnt_reg   <= rpt;
                  state_reg <= PG_SHIFT;
               end
            end
            PG_SHIFT: begin
               if (sh_last) begin
`ifdef PATTERN_GEN_PARITY_EN
                  state_reg <= PG_PAR;
`else
                  if (frame_more)
                     cnt_reg <= cnt_reg - CNT_W'(1);
                  else
                     state_reg <= PG_FIN;
`endif
               end
            end
`ifdef PATTERN_GEN_PARITY_EN
            PG_PAR: begin
               if (frame_more) begin
                  cnt_reg   <= cnt_reg - CNT_W'(1);
                  state_reg <= PG_SHIFT;
               end else begin
                  state_reg <= PG_FIN;
               end
            end
`endif
            PG_FIN:  state_reg <= PG_IDLE;
            default: state_reg <= PG_IDLE;
         endcase
      end
   end

   assign ready     = (state_reg == PG_IDLE);
   assign busy      = (state_reg != PG_IDLE);
   assign done      = (state_reg == PG_FIN);
   assign out_valid = (state_reg == PG_SHIFT) || (state_reg == PG_PAR);
   assign out       = (state_reg == PG_SHIFT) ? sh_bit :
                      (state_reg == PG_PAR)   ? sh_par : 1'b0;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: self-checking bench for pattern_gen. A queue-based model
// expands each accepted request into its expected bit stream; a compare
// process checks every output on every falling edge, and directed
// transactions pin the captured streams to hand-computed literals.
// Honors PATTERN_GEN_PARITY_EN when it is defined for the build.
module tb_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pat_data = '0;
   logic [3:0] pat_len = '0;
   logic [3:0] rpt = '0;
   logic       ready, out, out_valid, busy, done;

   int total = 0;
   int bad   = 0;

   pattern_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pat_data  (pat_data),
      .pat_len   (pat_len),
      .rpt       (rpt),
      .ready     (ready),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   bit mq[$];
   bit m_idle = 1'b1;
   bit m_fin  = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_idle = 1'b1;
         m_fin  = 1'b0;
      end else if (m_fin) begin
         m_fin  = 1'b0;
         m_idle = 1'b1;
      end else if (m_idle) begin
         if (start) begin
            int l;
            l = (pat_len == 0 || pat_len > 8) ? 8 : int'(pat_len);
            for (int f = 0; f <= int'(rpt); f++) begin
               bit p;
               p = 1'b0;
               for (int i = l - 1; i >= 0; i--) begin
                  mq.push_back(pat_data[i]);
                  p ^= pat_data[i];
               end
`ifdef PATTERN_GEN_PARITY_EN
               mq.push_back(p);
`endif
            end
            m_idle = 1'b0;
         end
      end else begin
         void'(mq.pop_front());
         if (mq.size() == 0)
            m_fin = 1'b1;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      bit ev, eo;
      ev = (mq.size() != 0);
      eo = ev ? mq[0] : 1'b0;
      chk("ready",     64'(ready),     64'(m_idle));
      chk("busy",      64'(busy),      64'(!m_idle));
      chk("done",      64'(done),      64'(m_fin));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out",       64'(out),       64'(eo));
   end

   // Stream capture.
   logic [63:0] cap = '0;
   int cap_n = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (out_valid) begin
         cap = {cap[62:0], out};
         cap_n++;
      end
      if (done)
         done_cnt++;
   end

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({name, " timeout"}, 64'(0), 64'(1));
   endtask

   task automatic xfer(input string name, input logic [7:0] d, input logic [3:0] l,
                       input logic [3:0] r, input logic [63:0] exp, input int exp_n);
      int d0;
      @(negedge clk);
      cap = '0;
      cap_n = 0;
      d0 = done_cnt;
      pat_data = d;
      pat_len  = l;
      rpt      = r;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      // Input changes after accept must not disturb the frame.
      pat_data = ~d;
      pat_len  = 4'd3;
      rpt      = 4'd7;
      wait_done(name);
      @(negedge clk);
      chk({name, " bits"},  cap, exp);
      chk({name, " count"}, 64'(cap_n), 64'(exp_n));
      chk({name, " done"},  64'(done_cnt - d0), 64'(1));
      $display("xfer %s: data=%h len=%0d rpt=%0d bits=%0d stream=%0b", name, d, l, r, cap_n, cap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("reset ready", 64'(ready), 64'(1));
      chk("reset busy",  64'(busy),  64'(0));
      chk("reset out_valid", 64'(out_valid), 64'(0));
      #20 rst = 1'b1;
      repeat (2) @(negedge clk);

`ifdef PATTERN_GEN_PARITY_EN
      xfer("basic",   8'h0D, 4'd4, 4'd0, 64'b11011, 5);
      xfer("rpt2",    8'h0D, 4'd4, 4'd2, 64'b110111101111011, 15);
      xfer("len0",    8'hA5, 4'd0, 4'd0, 64'b101001010, 9);
      xfer("rpt1",    8'h0D, 4'd4, 4'd1, 64'b1101111011, 10);
      xfer("len9",    8'hA5, 4'd9, 4'd0, 64'b101001010, 9);
      xfer("len1",    8'h01, 4'd1, 4'd3, 64'b11111111, 8);
`else
      xfer("basic",   8'h0D, 4'd4, 4'd0, 64'b1101, 4);
      xfer("rpt2",    8'h0D, 4'd4, 4'd2, 64'b110111011101, 12);
      xfer("len0",    8'hA5, 4'd0, 4'd0, 64'b10100101, 8);
      xfer("rpt1",    8'h0D, 4'd4, 4'd1, 64'b11011101, 8);
      xfer("len9",    8'hA5, 4'd9, 4'd0, 64'b10100101, 8);
      xfer("len1",    8'h01, 4'd1, 4'd3, 64'b1111, 4);
`endif

      // start held high: second transfer begins one cycle after ready rises.
      begin
         int g, d0;
         @(negedge clk);
         d0 = done_cnt;
         pat_data = 8'h0D;
         pat_len  = 4'd4;
         rpt      = 4'd0;
         start    = 1'b1;
         wait_done("hold first");
         g = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            g++;
            if (out_valid) break;
         end
         start = 1'b0;
         chk("hold gap", 64'(g), 64'(2));
         wait_done("hold second");
         repeat (3) @(negedge clk);
         chk("hold done count", 64'(done_cnt - d0), 64'(2));
         $display("xfer hold: gap=%0d dones=%0d", g, done_cnt - d0);
      end

      // Reset during the third bit.
      begin
         int v, d0;
         @(negedge clk);
         pat_data = 8'hA5;
         pat_len  = 4'd8;
         rpt      = 4'd1;
         start    = 1'b1;
         @(negedge clk);
         start = 1'b0;
         v = out_valid ? 1 : 0;
         for (int k = 0; k < 20 && v < 3; k++) begin
            @(negedge clk);
            if (out_valid) v++;
         end
         chk("rst reached bit3", 64'(v), 64'(3));
         #2 rst = 1'b0;
         #1;
         chk("rst out",       64'(out),       64'(0));
         chk("rst out_valid", 64'(out_valid), 64'(0));
         chk("rst busy",      64'(busy),      64'(0));
         chk("rst ready",     64'(ready),     64'(1));
         @(negedge clk);
         #1 rst = 1'b1;
         d0 = done_cnt;
         repeat (20) @(negedge clk);
         chk("rst no done", 64'(done_cnt - d0), 64'(0));
         $display("xfer reset: aborted at bit %0d dones_after=%0d", v, done_cnt - d0);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
